// File: rtl/mem_access_ctrl.sv
// Data-memory port initiator: byte/half/word loads and stores, little-endian, with
// read-modify-write for sub-word stores. Optional misalignment trap: MEM_MISALIGN_TRAP_EN.
module mem_access_ctrl #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [AddrWidth-1:0] Addr,
    output logic                 R,
    output logic                 W,
    output logic [DataWidth-1:0] W_data,
    input  logic [DataWidth-1:0] R_data
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RSP  = 2'b11
    } state_t;

    state_t                 state_r, state_s;
    logic                   req_ready_r, req_ready_s;
    logic                   rsp_valid_r, rsp_valid_s;
    logic [DataWidth-1:0]   rsp_rdata_r, rsp_rdata_s;
    logic                   rsp_err_r, rsp_err_s;
    logic [AddrWidth-1:0]   addr_r, addr_s;
    logic                   r_r, r_s;
    logic                   w_r, w_s;
    logic [DataWidth-1:0]   w_data_r, w_data_s;
    logic                   accept_s;
    logic                   err_s;

    logic                   we_r;
    logic [1:0]             size_r;
    logic                   signed_r;
    logic [1:0]             lane_r;
    logic [DataWidth-1:0]   wdata_r;

    // Pick the addressed lane out of a RAM word and extend it to full width.
    function automatic logic [DataWidth-1:0] load_extend(
        input logic [DataWidth-1:0] word,
        input logic [1:0]           size,
        input logic                 sgn,
        input logic [1:0]           lane
    );
        logic [7:0]           b;
        logic [15:0]          h;
        logic [DataWidth-1:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
            2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overwrite only the addressed lane of the old word with the store data.
    function automatic logic [DataWidth-1:0] store_merge(
        input logic [DataWidth-1:0] old_word,
        input logic [DataWidth-1:0] wdata,
        input logic [1:0]           size,
        input logic [1:0]           lane
    );
        logic [DataWidth-1:0] res;
        res = old_word;
        case (size)
            2'b00:   res[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned half/word or reserved size is rejected before touching the RAM.
    function automatic logic access_err(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic err;
        case (size)
            2'b00:   err = 1'b0;
            2'b01:   err = lane[0];
            2'b10:   err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction
`endif

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_s     = state_r;
        req_ready_s = req_ready_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        addr_s      = addr_r;
        r_s         = r_r;
        w_s         = w_r;
        w_data_s    = w_data_r;
        accept_s    = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid && req_ready_r) begin
                    accept_s    = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                    err_s       = access_err(req_size, req_addr[1:0]);
`else
                    err_s       = 1'b0;
`endif
                    req_ready_s = 1'b0;
                    if (err_s) begin
                        state_s     = RSP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = {DataWidth{1'b0}};
                    end else if (req_we && req_size[1]) begin
                        // Full-word store (size 11 only reaches here untrapped) skips the read.
                        state_s  = WR;
                        addr_s   = {req_addr[AddrWidth-1:2], 2'b00};
                        w_s      = 1'b1;
                        w_data_s = req_wdata;
                    end else begin
                        state_s = RD;
                        addr_s  = {req_addr[AddrWidth-1:2], 2'b00};
                        r_s     = 1'b1;
                    end
                end else begin
                    accept_s = 1'b0;
                end
            end
            RD: begin
                r_s = 1'b0;
                if (we_r) begin
                    state_s  = WR;
                    w_s      = 1'b1;
                    w_data_s = store_merge(R_data, wdata_r, size_r, lane_r);
                end else begin
                    state_s     = RSP;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b0;
                    rsp_rdata_s = load_extend(R_data, size_r, signed_r, lane_r);
                end
            end
            WR: begin
                w_s         = 1'b0;
                state_s     = RSP;
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b0;
                rsp_rdata_s = {DataWidth{1'b0}};
            end
            RSP: begin
                if (rsp_ready) begin
                    state_s     = IDLE;
                    rsp_valid_s = 1'b0;
                    rsp_err_s   = 1'b0;
                    req_ready_s = 1'b1;
                    r_s         = 1'b0;
                    w_s         = 1'b0;
                end else begin
                    state_s = RSP;
                end
            end
            default: begin
                state_s     = IDLE;
                req_ready_s = 1'b1;
                rsp_valid_s = 1'b0;
                rsp_err_s   = 1'b0;
                r_s         = 1'b0;
                w_s         = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DataWidth{1'b0}};
            rsp_err_r   <= 1'b0;
            addr_r      <= {AddrWidth{1'b0}};
            r_r         <= 1'b0;
            w_r         <= 1'b0;
            w_data_r    <= {DataWidth{1'b0}};
        end else begin
            state_r     <= state_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            addr_r      <= addr_s;
            r_r         <= r_s;
            w_r         <= w_s;
            w_data_r    <= w_data_s;
        end
    end

    // Request fields held for the RD/WR phases.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            we_r     <= 1'b0;
            size_r   <= 2'b00;
            signed_r <= 1'b0;
            lane_r   <= 2'b00;
            wdata_r  <= {DataWidth{1'b0}};
        end else if (accept_s) begin
            we_r     <= req_we;
            size_r   <= req_size;
            signed_r <= req_signed;
            lane_r   <= req_addr[1:0];
            wdata_r  <= req_wdata;
        end else begin
            we_r     <= we_r;
            size_r   <= size_r;
            signed_r <= signed_r;
            lane_r   <= lane_r;
            wdata_r  <= wdata_r;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign Addr      = addr_r;
    assign R         = r_r;
    assign W         = w_r;
    assign W_data    = w_data_r;

endmodule
